// File: rtl/screen_sequencer.sv
// Game screen sequencer: TITLE/IDLE/COUNTDOWN/PLAY/PAUSE/WON FSM with a full-frame redraw sweep.
// Latency: one cycle from button edge or game_over to new screen; never back-pressured, and transitions restart any sweep.
module screen_sequencer #(
  parameter int TICK_DIV      = 50000000,
  parameter int COUNTDOWN_SEC = 5
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       game_over,
  input  logic       winner,
  output logic [2:0] screen_sel,
  output logic [6:0] screen_en,
  output logic [2:0] count_val,
  output logic [7:0] redraw_x,
  output logic [6:0] redraw_y,
  output logic       redraw_plot,
  output logic       redraw_busy,
  output logic       game_run
);

  localparam int             TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [2:0]     COUNT_INIT = 3'(COUNTDOWN_SEC);
  localparam logic [7:0]     X_LAST     = 8'd159;
  localparam logic [6:0]     Y_LAST     = 7'd119;

  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_IDLE      = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
    S_PAUSE     = 3'd4,
    S_A_WON     = 3'd5,
    S_B_WON     = 3'd6
  } state_t;

  state_t        state, next_state;
  logic          start_q, pause_q;
  logic          start_e, pause_e;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [2:0]    count_nxt;
  logic          tick_wrap;

  logic [7:0]    x_nxt;
  logic [6:0]    y_nxt;
  logic          busy_nxt;
  logic          state_chg;
  logic [6:0]    en_nxt;
  logic          run_nxt;

  // Next-state and countdown datapath
  always_comb begin
    start_e    = start_btn & ~start_q;
    pause_e    = pause_btn & ~pause_q;
    tick_wrap  = (tick_cnt == TICK_LAST);
    next_state = state;
    tick_nxt   = '0;
    count_nxt  = '0;
    case (state)
      S_TITLE: begin
        if (start_e) next_state = S_IDLE;
      end
      S_IDLE: begin
        if (start_e) begin
          next_state = S_COUNTDOWN;
          count_nxt  = COUNT_INIT;
        end
      end
      S_COUNTDOWN: begin
        count_nxt = count_val;
        tick_nxt  = tick_cnt + TW'(1);
        if (tick_wrap) begin
          tick_nxt = '0;
          if (count_val <= 3'd1) begin
            next_state = S_PLAY;
            count_nxt  = '0;
          end else begin
            count_nxt = count_val - 3'd1;
          end
        end
      end
      S_PLAY: begin
        // game_over takes priority over a simultaneous pause edge
        if (game_over)    next_state = winner ? S_B_WON : S_A_WON;
        else if (pause_e) next_state = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause_e) next_state = S_PLAY;
      end
      S_A_WON, S_B_WON: begin
        if (start_e) next_state = S_IDLE;
      end
      default: next_state = S_TITLE;
    endcase
  end

  // Redraw sweep: raster x inside y, restarted on every screen change
  always_comb begin
    state_chg = (next_state != state);
    x_nxt     = redraw_x;
    y_nxt     = redraw_y;
    busy_nxt  = redraw_busy;
    if (state_chg) begin
      x_nxt    = '0;
      y_nxt    = '0;
      busy_nxt = 1'b1;
    end else if (redraw_busy) begin
      if (redraw_x == X_LAST) begin
        x_nxt = '0;
        if (redraw_y == Y_LAST) begin
          y_nxt    = '0;
          busy_nxt = 1'b0;
        end else begin
          y_nxt = redraw_y + 7'd1;
        end
      end else begin
        x_nxt = redraw_x + 8'd1;
      end
    end
    en_nxt  = 7'd1 << next_state;
    run_nxt = (next_state == S_PLAY) && !busy_nxt;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= S_TITLE;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      tick_cnt    <= '0;
      count_val   <= '0;
      screen_en   <= 7'b0000001;
      redraw_x    <= '0;
      redraw_y    <= '0;
      redraw_busy <= 1'b1;
      redraw_plot <= 1'b1;
      game_run    <= 1'b0;
    end else begin
      state       <= next_state;
      start_q     <= start_btn;
      pause_q     <= pause_btn;
      tick_cnt    <= tick_nxt;
      count_val   <= count_nxt;
      screen_en   <= en_nxt;
      redraw_x    <= x_nxt;
      redraw_y    <= y_nxt;
      redraw_busy <= busy_nxt;
      redraw_plot <= busy_nxt;
      game_run    <= run_nxt;
    end
  end

  assign screen_sel = state;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with TICK_DIV=4, COUNTDOWN_SEC=3.
module tb_screen_sequencer;

  logic       CLOCK_50  = 1'b0;
  logic       resetn    = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       game_over = 1'b0;
  logic       winner    = 1'b0;
  logic [2:0] screen_sel;
  logic [6:0] screen_en;
  logic [2:0] count_val;
  logic [7:0] redraw_x;
  logic [6:0] redraw_y;
  logic       redraw_plot;
  logic       redraw_busy;
  logic       game_run;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  screen_sequencer #(.TICK_DIV(4), .COUNTDOWN_SEC(3)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .game_over   (game_over),
    .winner      (winner),
    .screen_sel  (screen_sel),
    .screen_en   (screen_en),
    .count_val   (count_val),
    .redraw_x    (redraw_x),
    .redraw_y    (redraw_y),
    .redraw_plot (redraw_plot),
    .redraw_busy (redraw_busy),
    .game_run    (game_run)
  );

  typedef struct {
    logic       start;
    logic       pause;
    logic       go;
    logic       win;
    int         idle;
    logic [2:0] sel;
    logic [6:0] en;
    logic [2:0] cnt;
    logic       busy;
    logic       run;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // gap edge, one edge with the vector's inputs, then idle edges, then compare
  task automatic run_vec(input int i);
    @(negedge CLOCK_50);
    start_btn = vecs[i].start;
    pause_btn = vecs[i].pause;
    game_over = vecs[i].go;
    winner    = vecs[i].win;
    @(negedge CLOCK_50);
    start_btn = 1'b0;
    pause_btn = 1'b0;
    game_over = 1'b0;
    winner    = 1'b0;
    repeat (vecs[i].idle) @(negedge CLOCK_50);
    check($sformatf("v%0d_sel", i),  32'(screen_sel),  32'(vecs[i].sel));
    check($sformatf("v%0d_en", i),   32'(screen_en),   32'(vecs[i].en));
    check($sformatf("v%0d_cnt", i),  32'(count_val),   32'(vecs[i].cnt));
    check($sformatf("v%0d_busy", i), 32'(redraw_busy), 32'(vecs[i].busy));
    check($sformatf("v%0d_run", i),  32'(game_run),    32'(vecs[i].run));
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int bad;
    int n;
    logic [7:0] lx;
    logic [6:0] ly;

    //            start pause go   win  idle sel   en          cnt   busy run
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 3'd4, 7'b0010000, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3'd4, 7'b0010000, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 3'd4, 7'b0010000, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 3'd3, 7'b0001000, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 3'd6, 7'b1000000, 3'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3'd1, 7'b0000010, 3'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 3'd1, 7'b0000010, 3'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 3'd1, 7'b0000010, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3'd2, 7'b0000100, 3'd3, 1'b1, 1'b0};
    // countdown entered at k=0; gap k=1, apply k=2, 10 idle -> k=12 lands in PLAY
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd3, 7'b0001000, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 3'd5, 7'b0100000, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3'd1, 7'b0000010, 3'd0, 1'b1, 1'b0};

    // Reset values
    repeat (3) @(negedge CLOCK_50);
    check("rst_sel",  32'(screen_sel),  32'd0);
    check("rst_en",   32'(screen_en),   32'b0000001);
    check("rst_cnt",  32'(count_val),   32'd0);
    check("rst_x",    32'(redraw_x),    32'd0);
    check("rst_y",    32'(redraw_y),    32'd0);
    check("rst_busy", 32'(redraw_busy), 32'd1);
    check("rst_plot", 32'(redraw_plot), 32'd1);
    check("rst_run",  32'(game_run),    32'd0);

    // Title sweep after release; pause/game_over in TITLE must not disturb it
    resetn = 1'b1;
    bad = 0;
    lx = '0;
    ly = '0;
    for (int k = 0; k < 19200; k++) begin
      if (redraw_x !== 8'(k % 160) || redraw_y !== 7'(k / 160) ||
          redraw_busy !== 1'b1 || redraw_plot !== 1'b1 || screen_sel !== 3'd0)
        bad++;
      if (k == 19199) begin
        lx = redraw_x;
        ly = redraw_y;
      end
      pause_btn = (k == 100);
      game_over = (k == 100);
      winner    = (k == 100);
      @(negedge CLOCK_50);
    end
    check("title_sweep_bad", 32'(bad), 32'd0);
    check("title_last_x", 32'(lx), 32'd159);
    check("title_last_y", 32'(ly), 32'd119);
    check("title_end_busy", 32'(redraw_busy), 32'd0);
    check("title_end_plot", 32'(redraw_plot), 32'd0);
    check("title_end_x", 32'(redraw_x), 32'd0);
    check("title_end_y", 32'(redraw_y), 32'd0);
    check("title_end_sel", 32'(screen_sel), 32'd0);

    // start held 10 cycles: exactly one transition to IDLE
    start_btn = 1'b1;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLOCK_50);
      if (screen_sel !== 3'd1) bad++;
    end
    check("hold_start_bad", 32'(bad), 32'd0);
    check("hold_start_x", 32'(redraw_x), 32'd9);
    check("hold_start_y", 32'(redraw_y), 32'd0);
    start_btn = 1'b0;

    // start_e at sweep pixel (40,10), then reset during countdown
    n = 0;
    while (!(redraw_x == 8'd40 && redraw_y == 7'd10) && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("reach_40_10", 32'(n < 5000), 32'd1);
    start_btn = 1'b1;
    @(negedge CLOCK_50);
    start_btn = 1'b0;
    check("cd1_sel",  32'(screen_sel),  32'd2);
    check("cd1_cnt",  32'(count_val),   32'd3);
    check("cd1_x",    32'(redraw_x),    32'd0);
    check("cd1_y",    32'(redraw_y),    32'd0);
    check("cd1_busy", 32'(redraw_busy), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    check("cd1_k5_cnt", 32'(count_val), 32'd2);
    check("cd1_k5_x",   32'(redraw_x),  32'd5);
    resetn = 1'b0;
    #1;
    check("mid_rst_sel",  32'(screen_sel),  32'd0);
    check("mid_rst_en",   32'(screen_en),   32'b0000001);
    check("mid_rst_cnt",  32'(count_val),   32'd0);
    check("mid_rst_x",    32'(redraw_x),    32'd0);
    check("mid_rst_busy", 32'(redraw_busy), 32'd1);
    check("mid_rst_run",  32'(game_run),    32'd0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("post_rst_sel",  32'(screen_sel),  32'd0);
    check("post_rst_cnt",  32'(count_val),   32'd0);
    check("post_rst_x",    32'(redraw_x),    32'd1);
    check("post_rst_busy", 32'(redraw_busy), 32'd1);

    // TITLE -> IDLE -> full countdown, with ignored inputs along the way
    start_btn = 1'b1;
    @(negedge CLOCK_50);
    start_btn = 1'b0;
    check("c_idle_sel", 32'(screen_sel), 32'd1);
    @(negedge CLOCK_50);
    start_btn = 1'b1;
    @(negedge CLOCK_50);
    start_btn = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      check($sformatf("cd_k%0d_sel", k), 32'(screen_sel), (k < 12) ? 32'd2 : 32'd3);
      check($sformatf("cd_k%0d_cnt", k), 32'(count_val), (k < 12) ? 32'(3 - k / 4) : 32'd0);
      pause_btn = (k == 5);
      game_over = (k == 5);
      winner    = (k == 5);
      start_btn = (k == 6);
      if (k < 12) @(negedge CLOCK_50);
    end
    check("play_entry_busy", 32'(redraw_busy), 32'd1);
    check("play_entry_run",  32'(game_run),    32'd0);
    check("play_entry_x",    32'(redraw_x),    32'd0);

    // PLAY <-> PAUSE table section
    for (int i = 0; i <= 3; i++) run_vec(i);

    // game_run stays low through the whole 19200-cycle sweep after resuming
    bad = 0;
    for (int k = 0; k < 19200; k++) begin
      if (game_run !== 1'b0 || redraw_busy !== 1'b1) bad++;
      @(negedge CLOCK_50);
    end
    check("resume_sweep_bad", 32'(bad), 32'd0);
    check("resume_end_busy",  32'(redraw_busy), 32'd0);
    check("resume_end_run",   32'(game_run),    32'd1);
    check("resume_end_sel",   32'(screen_sel),  32'd3);

    for (int i = 4; i <= 11; i++) run_vec(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
